// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM states, error codes,
// well-known command bytes and the frame builder.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_START     = 3'd3,
    ST_SHIFT     = 3'd4,
    ST_ACK       = 3'd5,
    ST_WAIT_IDLE = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_NOACK    = 2'b01,
    ERR_START_TO = 2'b10,
    ERR_XFER_TO  = 2'b11
  } err_e;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] ACK_BYTE     = 8'hFA;

  // Index of the frame position that follows the stop bit.
  localparam logic [3:0] IDX_AFTER_STOP = 4'd10;

  // Frame shifted out LSB first after the start bit: data, odd parity, stop.
  function automatic logic [9:0] build_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_host_tx_line_filter.sv
// Two-flop synchroniser plus glitch filter for one PS/2 line. The filtered
// level only follows the pin after FILTER_LEN consecutive differing samples;
// fall pulses for one cycle when the filtered level goes 1 -> 0.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic level,
  output logic fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive samples that disagree with the current filtered level.
  always_comb begin
    level_d = level_q;
    fall_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        fall_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser and filter state; idle PS/2 lines read high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= line_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, shifts
// one command byte out on device clock falling edges and reports the ACK.
//
// Handshake: a byte is accepted on a rising clk edge where tx_valid && tx_ready;
// tx_ready is high only in IDLE, so tx_valid while busy is simply ignored.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int START_TIMEOUT  = 1500000,
  parameter int XFER_TIMEOUT   = 200000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] err_code,
  output logic [2:0] dbg_state
);

  localparam int IW   = $clog2(INHIBIT_CYCLES + 1);
  localparam int TMAX = (START_TIMEOUT > XFER_TIMEOUT) ? START_TIMEOUT : XFER_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [IW-1:0] INH_LAST   = IW'(INHIBIT_CYCLES - 1);
  localparam logic [IW-1:0] INH_SAT    = IW'(INHIBIT_CYCLES);
  localparam logic [TW-1:0] START_LAST = TW'(START_TIMEOUT - 1);
  localparam logic [TW-1:0] XFER_LAST  = TW'(XFER_TIMEOUT - 1);
  localparam logic [TW-1:0] TO_SAT     = TW'(TMAX);

  logic c_level, c_fall;
  logic d_level, d_fall_unused;

  state_e        state_q, state_d;
  logic [IW-1:0] inh_cnt_q, inh_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [9:0]    frame_q, frame_d;
  logic [3:0]    idx_q, idx_d;
  logic          ack_ok_q, ack_ok_d;
  logic          ps2c_oe_q, ps2c_oe_d;
  logic          ps2d_oe_q, ps2d_oe_d;
  logic          tx_ready_q, tx_ready_d;
  logic          busy_q, busy_d;
  logic          tx_done_q, tx_done_d;
  logic          tx_err_q, tx_err_d;
  err_e          err_code_q, err_code_d;
  logic          abort;
  err_e          abort_code;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_c (
    .clk     (clk),
    .reset   (reset),
    .line_in (ps2c_in),
    .level   (c_level),
    .fall    (c_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_d (
    .clk     (clk),
    .reset   (reset),
    .line_in (ps2d_in),
    .level   (d_level),
    .fall    (d_fall_unused)
  );

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_d    = state_q;
    inh_cnt_d  = inh_cnt_q;
    to_cnt_d   = to_cnt_q;
    frame_d    = frame_q;
    idx_d      = idx_q;
    ack_ok_d   = ack_ok_q;
    ps2c_oe_d  = ps2c_oe_q;
    ps2d_oe_d  = ps2d_oe_q;
    tx_done_d  = 1'b0;
    tx_err_d   = 1'b0;
    err_code_d = ERR_NONE;
    abort      = 1'b0;
    abort_code = ERR_NONE;

    case (state_q)
      ST_IDLE: begin
        ps2c_oe_d = 1'b0;
        ps2d_oe_d = 1'b0;
        if (tx_valid && tx_ready_q) begin
          frame_d   = build_frame(tx_data);
          inh_cnt_d = '0;
          ps2c_oe_d = 1'b1;
          state_d   = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        if (inh_cnt_q == INH_LAST) begin
          ps2d_oe_d = 1'b1;
          state_d   = ST_REQ;
        end else begin
          inh_cnt_d = (inh_cnt_q == INH_SAT) ? inh_cnt_q : inh_cnt_q + 1'b1;
        end
      end

      // One cycle with both lines low, then release clock keeping the start bit.
      ST_REQ: begin
        ps2c_oe_d = 1'b0;
        ps2d_oe_d = 1'b1;
        to_cnt_d  = '0;
        state_d   = ST_START;
      end

      ST_START: begin
        if (c_fall) begin
          ps2d_oe_d = ~frame_q[0];
          idx_d     = 4'd1;
          to_cnt_d  = '0;
          state_d   = ST_SHIFT;
        end else if (to_cnt_q == START_LAST) begin
          abort      = 1'b1;
          abort_code = ERR_START_TO;
        end else begin
          to_cnt_d = (to_cnt_q == TO_SAT) ? to_cnt_q : to_cnt_q + 1'b1;
        end
      end

      ST_SHIFT: begin
        if (to_cnt_q == XFER_LAST) begin
          abort      = 1'b1;
          abort_code = ERR_XFER_TO;
        end else begin
          to_cnt_d = (to_cnt_q == TO_SAT) ? to_cnt_q : to_cnt_q + 1'b1;
          if (c_fall) begin
            if (idx_q == IDX_AFTER_STOP) begin
              ps2d_oe_d = 1'b0;
              state_d   = ST_ACK;
            end else begin
              ps2d_oe_d = ~frame_q[idx_q];
              idx_d     = idx_q + 4'd1;
            end
          end
        end
      end

      ST_ACK: begin
        if (to_cnt_q == XFER_LAST) begin
          abort      = 1'b1;
          abort_code = ERR_XFER_TO;
        end else begin
          to_cnt_d = (to_cnt_q == TO_SAT) ? to_cnt_q : to_cnt_q + 1'b1;
          if (c_fall) begin
            ack_ok_d = ~d_level;
            state_d  = ST_WAIT_IDLE;
          end
        end
      end

      // Let the device finish its ACK pulse before reporting the outcome.
      ST_WAIT_IDLE: begin
        ps2c_oe_d = 1'b0;
        ps2d_oe_d = 1'b0;
        if (c_level && d_level) begin
          state_d = ST_IDLE;
          if (ack_ok_q) begin
            tx_done_d = 1'b1;
          end else begin
            tx_err_d   = 1'b1;
            err_code_d = ERR_NOACK;
          end
        end
      end

      default: begin
        ps2c_oe_d = 1'b0;
        ps2d_oe_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase

    if (abort) begin
      state_d    = ST_IDLE;
      ps2c_oe_d  = 1'b0;
      ps2d_oe_d  = 1'b0;
      tx_done_d  = 1'b0;
      tx_err_d   = 1'b1;
      err_code_d = abort_code;
    end

    tx_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
  end

  // Single register bank for FSM state, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      inh_cnt_q  <= '0;
      to_cnt_q   <= '0;
      frame_q    <= '0;
      idx_q      <= '0;
      ack_ok_q   <= 1'b0;
      ps2c_oe_q  <= 1'b0;
      ps2d_oe_q  <= 1'b0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_err_q   <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      inh_cnt_q  <= inh_cnt_d;
      to_cnt_q   <= to_cnt_d;
      frame_q    <= frame_d;
      idx_q      <= idx_d;
      ack_ok_q   <= ack_ok_d;
      ps2c_oe_q  <= ps2c_oe_d;
      ps2d_oe_q  <= ps2d_oe_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      tx_done_q  <= tx_done_d;
      tx_err_q   <= tx_err_d;
      err_code_q <= err_code_d;
    end
  end

  assign tx_ready  = tx_ready_q;
  assign busy      = busy_q;
  assign ps2c_oe   = ps2c_oe_q;
  assign ps2d_oe   = ps2d_oe_q;
  assign tx_done   = tx_done_q;
  assign tx_err    = tx_err_q;
  assign err_code  = err_code_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the
// host; a frame model built from the byte value predicts every wire bit.
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int INH  = 50;
  localparam int STO  = 1000;
  localparam int XTO  = 5000;
  localparam int HALF = 40;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2c_oe, ps2d_oe, busy, tx_done, tx_err;
  logic [1:0] err_code;
  logic [2:0] dbg_state;
  logic       dev_c = 1'b1;
  logic       dev_d = 1'b1;
  logic       ps2c_line, ps2d_line;

  assign ps2c_line = dev_c & ~ps2c_oe;
  assign ps2d_line = dev_d & ~ps2d_oe;

  initial forever #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .START_TIMEOUT  (STO),
    .XFER_TIMEOUT   (XTO),
    .FILTER_LEN     (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .ps2c_in   (ps2c_line),
    .ps2d_in   (ps2d_line),
    .ps2c_oe   (ps2c_oe),
    .ps2d_oe   (ps2d_oe),
    .busy      (busy),
    .tx_done   (tx_done),
    .tx_err    (tx_err),
    .err_code  (err_code),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [10:0] exp_q[$];

  int cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int start_cyc = 0, err_cyc = 0;
  logic [1:0] last_code = '0, done_code = '0, err_oe = '0;
  logic prev_c_oe = 1'b0, prev_d_oe = 1'b0;

  // Output monitor, sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (tx_done) begin
      done_cnt++;
      done_code = err_code;
    end
    if (tx_err) begin
      err_cnt++;
      last_code = err_code;
      err_cyc = cyc;
      err_oe = {ps2c_oe, ps2d_oe};
    end
    if (tx_done && tx_err) both_cnt++;
    if (prev_c_oe && prev_d_oe && !ps2c_oe && ps2d_oe) start_cyc = cyc;
    prev_c_oe = ps2c_oe;
    prev_d_oe = ps2d_oe;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: start 0, data LSB first, odd parity, stop 1 (wire order).
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = (($countones(b) % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    while (!tx_ready && n < 20000) begin @(negedge clk); n++; end
    check("ready_before_send", 32'(tx_ready), 32'd1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    exp_q.push_back(frame_of(b));
    check("accept_ready_busy_clkoe", {29'd0, tx_ready, busy, ps2c_oe}, 32'b011);
  endtask

  // Device model: waits for the request, produces n_falls clock pulses,
  // samples the data line on each rising edge, optionally ACKs on pulse 12.
  task automatic dev_run(input int n_falls, input bit ack_low, input int hold,
                         output logic [10:0] cap, output int pend);
    int n;
    cap  = '0;
    pend = -1;
    n = 0;
    while (!(ps2c_oe === 1'b0 && ps2d_oe === 1'b1 && busy === 1'b1) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("request_seen", 32'(n < 2000), 32'd1);
    repeat (HALF) @(negedge clk);
    cap[0] = ps2d_line;
    for (int k = 1; k <= n_falls; k++) begin
      dev_c = 1'b0;
      repeat (HALF) @(negedge clk);
      if (k == 12) begin
        repeat (hold) @(negedge clk);
        pend = done_cnt + err_cnt;
      end
      dev_c = 1'b1;
      if (k <= 10) cap[k] = ps2d_line;
      if (k == 11 && ack_low) dev_d = 1'b0;
      if (k == 12) dev_d = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    dev_c = 1'b1;
    dev_d = 1'b1;
  endtask

  task automatic wait_end(input int base, input int limit);
    int n;
    n = 0;
    while (done_cnt + err_cnt == base && n < limit) begin @(negedge clk); n++; end
    check("end_seen", 32'(done_cnt + err_cnt != base), 32'd1);
  endtask

  task automatic do_xfer(input logic [7:0] b, input bit ack_low, input bit poke);
    int pre_d, pre_e, pend;
    logic [10:0] cap, exp;
    pre_d = done_cnt;
    pre_e = err_cnt;
    send_byte(b);
    if (poke) begin
      tx_data  = 8'h55;
      tx_valid = 1'b1;
      repeat (5) @(negedge clk);
      check("ready_low_while_busy", 32'(tx_ready), 32'd0);
      tx_valid = 1'b0;
      tx_data  = 8'h00;
    end
    dev_run(12, ack_low, 100, cap, pend);
    check("no_early_end", 32'(pend), 32'(pre_d + pre_e));
    wait_end(pre_d + pre_e, 300);
    exp = exp_q.pop_front();
    check("wire_frame", 32'(cap), 32'(exp));
    if (ack_low) begin
      check("done_count", 32'(done_cnt), 32'(pre_d + 1));
      check("err_count", 32'(err_cnt), 32'(pre_e));
      check("done_err_code", 32'(done_code), 32'd0);
    end else begin
      check("err_count_nack", 32'(err_cnt), 32'(pre_e + 1));
      check("done_count_nack", 32'(done_cnt), 32'(pre_d));
      check("nack_code", 32'(last_code), 32'b01);
    end
    repeat (2) @(negedge clk);
    check("ready_after", {30'd0, tx_ready, busy}, 32'b10);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int pre_e, pend;
    logic [10:0] cap, exp;
    logic [7:0] rb;

    repeat (5) @(negedge clk);
    check("reset_ready_busy", {30'd0, tx_ready, busy}, 32'b10);
    check("reset_oe", {30'd0, ps2c_oe, ps2d_oe}, 32'b00);
    check("reset_done_err_code", {28'd0, tx_done, tx_err, err_code}, 32'd0);
    reset = 1'b1;
    repeat (20) @(negedge clk);

    do_xfer(CMD_SET_LEDS, 1'b1, 1'b0);
    do_xfer(8'h07, 1'b1, 1'b0);
    do_xfer(8'h00, 1'b1, 1'b0);
    do_xfer(CMD_ENABLE, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      rb = 8'($urandom_range(0, 255));
      do_xfer(rb, 1'($urandom_range(0, 1)), 1'b0);
    end
    do_xfer(CMD_RESET, 1'b0, 1'b0);

    // Device never clocks: start timeout.
    pre_e = err_cnt;
    send_byte(8'h3C);
    void'(exp_q.pop_front());
    wait_end(done_cnt + err_cnt, 3000);
    check("start_to_code", 32'(last_code), 32'b10);
    check("start_to_latency", 32'(err_cyc - start_cyc), 32'(STO));
    check("start_to_oe", 32'(err_oe), 32'b00);
    check("start_to_err_count", 32'(err_cnt), 32'(pre_e + 1));

    // Device stops after 4 clock pulses: transfer timeout.
    repeat (20) @(negedge clk);
    send_byte(8'hA5);
    exp = exp_q.pop_front();
    dev_run(4, 1'b0, 0, cap, pend);
    check("xfer_partial_bits", 32'(cap[4:0]), 32'(exp[4:0]));
    wait_end(done_cnt + err_cnt, 7000);
    check("xfer_to_code", 32'(last_code), 32'b11);
    check("xfer_to_oe", 32'(err_oe), 32'b00);
    @(negedge clk);
    check("xfer_to_ready", {30'd0, tx_ready, busy}, 32'b10);

    // Reset asserted mid-transfer while the host drives a 0 data bit.
    repeat (20) @(negedge clk);
    send_byte(8'h0F);
    void'(exp_q.pop_front());
    dev_run(5, 1'b0, 0, cap, pend);
    check("pre_reset_drive", {30'd0, ps2c_oe, ps2d_oe}, 32'b01);
    reset = 1'b0;
    #1;
    check("reset_mid_oe", {30'd0, ps2c_oe, ps2d_oe}, 32'b00);
    check("reset_mid_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("after_reset_ready", {30'd0, tx_ready, busy}, 32'b10);

    check("done_err_exclusive", 32'(both_cnt), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
